riscv_mul_arb: RTL

RISCV_MUL_ARB -- requirements
Module: riscv_mul_arb

---
 rtl/riscv_pkg.sv | 10 +
 rtl/riscv_rr_arb2.sv | 12 +
 rtl/wallace_multiplier.sv | 12 +
 rtl/riscv_mul_arb.sv | 119 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types used by the multiplier arbiter.
package riscv_pkg;

    localparam int XLEN            = 32;
    localparam int MUL_LAT_DEFAULT = 2;

    // Requester id: 0 or 1.
    typedef logic req_id_t;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module riscv_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    assign gnt[0] = en & req[0] & (~req[1] | last);
    assign gnt[1] = en & req[1] & (~req[0] | ~last);

endmodule

// File: rtl/wallace_multiplier.sv
// Low-W-bit product of two W-bit operands; the low half is sign-agnostic.
module wallace_multiplier #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p
);

    assign o_p = i_a * i_b;

endmodule

// File: rtl/riscv_mul_arb.sv
// Two requesters sharing one pipelined 32x32 low-product multiplier.
// Operand capture -> multiplier -> product stages; the whole pipe freezes on a response stall.
module riscv_mul_arb
    import riscv_pkg::*;
#(
    parameter int LATENCY = MUL_LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,
    output logic            busy
);

    logic            w_stall;
    logic            w_en;
    logic [1:0]      w_gnt;
    logic            r_last;

    logic            r_cap_v;
    req_id_t         r_cap_tag;
    logic [XLEN-1:0] r_cap_a;
    logic [XLEN-1:0] r_cap_b;
    logic [XLEN-1:0] w_prod;

    // Stage 1 is the operand capture register viewed through the multiplier.
    logic [LATENCY:1]            w_vld;
    req_id_t [LATENCY:1]         w_tag;
    logic [LATENCY:1][XLEN-1:0]  w_data;

    assign w_en = rst_n & ~w_stall;

    // Ready is the grant this requester would get if it asked, so it never looks at its own valid.
    assign req0_ready = w_en & (r_last | ~req1_valid);
    assign req1_ready = w_en & (~r_last | ~req0_valid);

    riscv_rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (r_last),
        .en   (w_en),
        .gnt  (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_cap_v <= 1'b0;
        end else begin
            if (|w_gnt)
                r_last <= w_gnt[1];
            if (!w_stall)
                r_cap_v <= |w_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_cap_tag <= w_gnt[1];
            r_cap_a   <= w_gnt[1] ? req1_a : req0_a;
            r_cap_b   <= w_gnt[1] ? req1_b : req0_b;
        end
    end

    wallace_multiplier #(.W(XLEN)) u_mul (
        .i_a (r_cap_a),
        .i_b (r_cap_b),
        .o_p (w_prod)
    );

    assign w_vld[1]  = r_cap_v;
    assign w_tag[1]  = r_cap_tag;
    assign w_data[1] = w_prod;

    for (genvar s = 2; s <= LATENCY; s++) begin : g_stg
        logic            r_v;
        req_id_t         r_t;
        logic [XLEN-1:0] r_d;

        // Bubbles advance with the data, so a stall holds gaps in place.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_v <= 1'b0;
            else if (!w_stall)
                r_v <= w_vld[s-1];
        end

        always_ff @(posedge clk) begin
            if (!w_stall) begin
                r_t <= w_tag[s-1];
                r_d <= w_data[s-1];
            end
        end

        assign w_vld[s]  = r_v;
        assign w_tag[s]  = r_t;
        assign w_data[s] = r_d;
    end

    assign w_stall = w_vld[LATENCY] & (w_tag[LATENCY] ? ~resp1_ready : ~resp0_ready);

    assign resp0_valid  = w_vld[LATENCY] & ~w_tag[LATENCY];
    assign resp1_valid  = w_vld[LATENCY] &  w_tag[LATENCY];
    assign resp0_result = w_data[LATENCY];
    assign resp1_result = w_data[LATENCY];
    assign busy         = |w_vld;

endmodule
